// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_pkg
//  Description : Shared limits, mode encodings and sizing helper for the
//                parameterised serial sequence detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

    // Legal pattern-length range
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    // Output timing modes
    localparam int MODE_MEALY = 0;
    localparam int MODE_MOORE = 1;

    // Bits needed to hold a fill count in the range 0..width
    function automatic int fill_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with a sticky flag that rises when
//                the count reaches all-ones and holds until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import seq_detect_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         sat_q;
    logic         sat_d;

    // Next count: step on inc, stop at all-ones; flag follows the new count
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
        sat_d = sat_q | (cnt_d == {W{1'b1}});
    end

    // Count and sticky flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Serial pattern detector with loadable pattern, selectable
//                overlapping/non-overlapping matching, Mealy or Moore output
//                and a saturating match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter int               OVERLAP = 1,
    parameter int               MOORE   = MODE_MEALY,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] DEF_PAT = WIDTH'(4'b1001)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] pat_in,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W    = fill_bits(WIDTH);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
    localparam logic [FILL_W-1:0] FILL_THR  = FILL_W'(WIDTH - 1);

    // Only the newest WIDTH-1 bits are kept: the oldest bit of a WIDTH-bit
    // window is shifted out in the same cycle the window is compared, so it
    // never takes part in a match and would be a dead flop.
    logic [WIDTH-2:0]  hist_q;
    logic [WIDTH-2:0]  hist_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [WIDTH-1:0]  pat_q;
    logic [WIDTH-1:0]  pat_d;
    logic [WIDTH-1:0]  window;
    logic              match;

    // Candidate window and match decision for the bit on `in` this cycle
    always_comb begin
        window = {hist_q, in};
        match  = en & ~load & (fill_q >= FILL_THR) & (window == pat_q);
    end

    // History, fill and pattern next-state; load wins over shifting
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        if (load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = window[WIDTH-2:0];
            if (match && (OVERLAP == 0)) begin
                // Non-overlapping: the next match must be built from fresh bits
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // History, fill and pattern registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PAT;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
        end
    end

    generate
        if (MOORE == MODE_MOORE) begin : g_moore
            logic out_q;
            logic out_d;

            // Registered indication: one cycle after the final pattern bit
            always_comb begin
                out_d = match;
            end

            // Output register
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_q <= 1'b0;
                end else begin
                    out_q <= out_d;
                end
            end

            assign out = out_q;
        end else begin : g_mealy
            assign out = match;
        end
    endgenerate

    sat_counter #(
        .W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .cnt   (match_cnt),
        .sat   (cnt_sat)
    );

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_param
//  Description : Directed, table-driven bench for seq_detect_param. Four
//                instances share one stimulus stream: overlapping Mealy,
//                non-overlapping Mealy, overlapping Moore and a 2-bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

    logic       clk;
    logic       reset;
    logic       in;
    logic       en;
    logic       load;
    logic [3:0] pat_in;

    logic       out_a, out_b, out_m, out_c;
    logic [7:0] cnt_a, cnt_b, cnt_m;
    logic [1:0] cnt_c;
    logic       sat_a, sat_b, sat_m, sat_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       ld;
        logic       in;
        logic [3:0] pat;
        logic       chk;
        logic       eo_a;
        logic       eo_b;
        logic       eo_m;
        logic [7:0] ec_a;
        logic [7:0] ec_b;
    } vec_t;

    vec_t vecs[$];

    seq_detect_param #(.OVERLAP(1), .MOORE(0)) u_a (
        .clk(clk), .reset(reset), .in(in), .en(en), .load(load), .pat_in(pat_in),
        .out(out_a), .match_cnt(cnt_a), .cnt_sat(sat_a));

    seq_detect_param #(.OVERLAP(0), .MOORE(0)) u_b (
        .clk(clk), .reset(reset), .in(in), .en(en), .load(load), .pat_in(pat_in),
        .out(out_b), .match_cnt(cnt_b), .cnt_sat(sat_b));

    seq_detect_param #(.OVERLAP(1), .MOORE(1)) u_m (
        .clk(clk), .reset(reset), .in(in), .en(en), .load(load), .pat_in(pat_in),
        .out(out_m), .match_cnt(cnt_m), .cnt_sat(sat_m));

    seq_detect_param #(.OVERLAP(1), .MOORE(0), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .in(in), .en(en), .load(load), .pat_in(pat_in),
        .out(out_c), .match_cnt(cnt_c), .cnt_sat(sat_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic l, input logic b,
                       input logic [3:0] p, input logic c,
                       input logic oa, input logic ob, input logic om,
                       input logic [7:0] ca, input logic [7:0] cb);
        vec_t v;
        v.rst = r; v.en = e; v.ld = l; v.in = b; v.pat = p; v.chk = c;
        v.eo_a = oa; v.eo_b = ob; v.eo_m = om; v.ec_a = ca; v.ec_b = cb;
        vecs.push_back(v);
    endtask

    initial begin
        int k;
        int exp_m;
        reset  = 1'b1;
        en     = 1'b0;
        load   = 1'b0;
        in     = 1'b0;
        pat_in = 4'b0000;

        // rst en ld in pat chk | out_a out_b out_m cnt_a cnt_b (before edge)
        add(1,0,0,0,4'h0,0, 0,0,0, 0,0);   // reset
        add(0,1,0,1,4'h0,1, 0,0,0, 0,0);   // stream 1001001
        add(0,1,0,0,4'h0,1, 0,0,0, 0,0);
        add(0,1,0,0,4'h0,1, 0,0,0, 0,0);
        add(0,1,0,1,4'h0,1, 1,1,0, 0,0);   // 4th bit: Mealy hits, Moore not yet
        add(0,1,0,0,4'h0,1, 0,0,1, 1,1);   // Moore one cycle later
        add(0,1,0,0,4'h0,1, 0,0,0, 1,1);
        add(0,1,0,1,4'h0,1, 1,0,0, 1,1);   // 7th bit: overlap only
        add(0,0,0,1,4'h0,1, 0,0,1, 2,1);
        add(1,1,0,0,4'h0,1, 0,0,0, 2,1);   // reset beats en
        add(0,1,0,1,4'h0,1, 0,0,0, 0,0);   // 100 then reset then 1
        add(0,1,0,0,4'h0,1, 0,0,0, 0,0);
        add(0,1,0,0,4'h0,1, 0,0,0, 0,0);
        add(1,0,0,0,4'h0,1, 0,0,0, 0,0);
        add(0,1,0,1,4'h0,1, 0,0,0, 0,0);   // partial match discarded
        add(0,1,0,0,4'h0,1, 0,0,0, 0,0);
        add(0,1,0,0,4'h0,1, 0,0,0, 0,0);
        add(0,1,0,1,4'h0,1, 1,1,0, 0,0);
        add(0,1,0,1,4'h0,1, 0,0,1, 1,1);   // 1 with en gaps 0 . 0 . 1
        add(0,0,0,0,4'h0,1, 0,0,0, 1,1);
        add(0,1,0,0,4'h0,1, 0,0,0, 1,1);
        add(0,0,0,1,4'h0,1, 0,0,0, 1,1);
        add(0,1,0,0,4'h0,1, 0,0,0, 1,1);
        add(0,1,0,1,4'h0,1, 1,1,0, 1,1);   // gapped pattern completes
        add(0,0,0,0,4'h0,1, 0,0,1, 2,2);
        add(0,1,0,0,4'h0,1, 0,0,0, 2,2);   // stream 01 ...
        add(0,1,0,1,4'h0,1, 0,0,0, 2,2);
        add(0,1,1,1,4'h6,1, 0,0,0, 2,2);   // load 0110 in place of 3rd bit
        add(0,1,0,0,4'h0,1, 0,0,0, 2,2);   // tail of interrupted stream
        add(0,1,0,0,4'h0,1, 0,0,0, 2,2);   // fresh 0110
        add(0,1,0,1,4'h0,1, 0,0,0, 2,2);
        add(0,1,0,1,4'h0,1, 0,0,0, 2,2);
        add(0,1,0,0,4'h0,1, 1,1,0, 2,2);
        add(0,0,0,0,4'h0,1, 0,0,1, 3,3);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset  = vecs[i].rst;
            en     = vecs[i].en;
            load   = vecs[i].ld;
            in     = vecs[i].in;
            pat_in = vecs[i].pat;
            #2;
            if (vecs[i].chk) begin
                check($sformatf("row%0d out_a", i), int'(out_a), int'(vecs[i].eo_a));
                check($sformatf("row%0d out_b", i), int'(out_b), int'(vecs[i].eo_b));
                check($sformatf("row%0d out_m", i), int'(out_m), int'(vecs[i].eo_m));
                check($sformatf("row%0d cnt_a", i), int'(cnt_a), int'(vecs[i].ec_a));
                check($sformatf("row%0d cnt_b", i), int'(cnt_b), int'(vecs[i].ec_b));
            end
        end

        // Counter saturation: stream 1001001001001001 on the default pattern
        @(negedge clk);
        reset = 1'b1; en = 1'b0; load = 1'b0; in = 1'b0; pat_in = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst cnt_c", int'(cnt_c), 0);
        check("rst sat_c", int'(sat_c), 0);
        check("rst sat_a", int'(sat_a), 0);
        check("rst out_m", int'(out_m), 0);
        k = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            en = 1'b1;
            in = ((i - 1) % 3 == 0) ? 1'b1 : 1'b0;
            exp_m = (i >= 4 && ((i - 4) % 3 == 0)) ? 1 : 0;
            #2;
            check($sformatf("sat bit%0d out_c", i), int'(out_c), exp_m);
            @(posedge clk);
            #1;
            k += exp_m;
            check($sformatf("sat bit%0d cnt_c", i), int'(cnt_c), (k > 3) ? 3 : k);
            check($sformatf("sat bit%0d sat_c", i), int'(sat_c), (k >= 3) ? 1 : 0);
            check($sformatf("sat bit%0d cnt_a", i), int'(cnt_a), k);
        end

        // Load leaves counter and sticky flag alone
        @(negedge clk);
        load = 1'b1; pat_in = 4'b0110; en = 1'b1; in = 1'b1;
        #2;
        check("load out_a", int'(out_a), 0);
        @(posedge clk);
        #1;
        check("load cnt_c", int'(cnt_c), 3);
        check("load sat_c", int'(sat_c), 1);
        check("load cnt_a", int'(cnt_a), 5);
        check("load sat_a", int'(sat_a), 0);

        // Reset clears the sticky flag
        @(negedge clk);
        load = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1;
        check("final rst sat_c", int'(sat_c), 0);
        check("final rst cnt_a", int'(cnt_a), 0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter OVERLAP, default 1: 1 = overlapping matches counted, 0 = non-overlapping.
REQ-003 SHALL have parameter MOORE, default 0: 0 = Mealy (combinational out), 1 = Moore (registered out).
REQ-004 SHALL have parameter CNT_W, default 8: match counter width.
REQ-005 SHALL have parameter DEF_PAT, default 4'b1001 (WIDTH bits): pattern after reset.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port in, input, 1 bit: serial data bit.
REQ-009 SHALL have port en, input, 1 bit: `in` is sampled only when en=1.
REQ-010 SHALL have port load, input, 1 bit: pattern-load strobe.
REQ-011 SHALL have port pat_in, input, WIDTH bits: new pattern, with the MSB matched first.
REQ-012 SHALL have port out, output, 1 bit: match indication.
REQ-013 SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.
REQ-014 SHALL have port cnt_sat, output, 1 bit: sticky flag, set when match_cnt is at all-ones.

Function
REQ-015 SHALL hold a WIDTH-bit history shift register (newest bit in the LSB) and a fill counter in the range 0..WIDTH.
REQ-016 SHALL, on each cycle with en=1 and load=0, shift `in` into the history and increment fill, saturating at WIDTH.
REQ-017 SHALL define match = en & ~load & (fill >= WIDTH-1) & ({hist[WIDTH-2:0], in} == pattern).
REQ-018 SHALL, when MOORE=0, drive out = match combinationally in the same cycle as the final pattern bit.
REQ-019 SHALL, when MOORE=1, drive out = match registered, so that out is high for exactly one cycle, one cycle after the final bit.
REQ-020 SHALL, when OVERLAP=1, keep history and fill unchanged after a match, so that later matches may reuse its bits.
REQ-021 SHALL, when OVERLAP=0, reset fill to 0 on a match, so that the next match needs WIDTH fresh bits.
REQ-022 SHALL, when en=0, hold history, fill and counter; out SHALL be 0 in Mealy mode.
REQ-023 SHALL, when load=1, capture pat_in into pattern and clear history and fill to 0; `in` is ignored that cycle and no match occurs.
REQ-024 SHALL increment match_cnt by 1 per match.
REQ-025 SHALL hold match_cnt at all-ones once reached (no wrap) and set cnt_sat, which stays set until reset.
REQ-026 SHALL treat load as non-interrupting for the counter: match_cnt and cnt_sat are unaffected by load.

Reset
REQ-027 SHALL, when reset=1 at a rising clk, set history=0, fill=0, pattern=DEF_PAT, match_cnt=0, cnt_sat=0 and registered out=0.
REQ-028 SHALL give reset priority over load and en.
REQ-029 SHALL, when reset is asserted mid-pattern, discard any partial match; detection restarts from an empty history.

Structure
REQ-030 SHALL place WIDTH limits (WIDTH_MIN=2, WIDTH_MAX=16) and mode constants (MODE_MEALY=0, MODE_MOORE=1) in package seq_detect_pkg.
REQ-031 SHALL implement the saturating counter as sub-module sat_counter (params W; ports clk, reset, inc, cnt, sat).
REQ-032 SHALL keep the remaining control (history, fill, compare) inside seq_detect_param.

Verification
REQ-033 SHALL cover: WIDTH=4, pattern 1001, OVERLAP=1, Mealy, stream 1001001 -> out high on the 4th and 7th bit cycles; match_cnt=2.
REQ-034 SHALL cover: same stream with OVERLAP=0 -> out high on the 4th bit only; match_cnt=1.
REQ-035 SHALL cover: MOORE=1, stream 1001 -> out high exactly one cycle after the 4th bit; never in the same cycle as it.
REQ-036 SHALL cover: load pat_in=0110 after bits 01 of a stream 0110 -> no match; fresh 0110 afterwards -> one match.
REQ-037 SHALL cover: CNT_W=2 with 5 matches -> match_cnt=3, cnt_sat=1 from the 3rd match onwards.
REQ-038 SHALL cover: reset after stream 100 then bit 1 -> out=0; en=0 gaps inside a pattern -> match still detected when the pattern completes.
